// File: rtl/fabric2_mdecoder_pkg.sv
// Shared OCP encodings, FSM state type and default address map for the v2 fabric decoder.
package fabric2_mdecoder_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int PORT_IDX_W = 3;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] FABRIC_P1_BASE = 32'h1000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P1_MASK = 32'hF000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P2_BASE = 32'h2000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P2_MASK = 32'hF000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P3_BASE = 32'h3000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P3_MASK = 32'hF000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P4_BASE = 32'h4000_0000;
  localparam logic [ADDR_WIDTH-1:0] FABRIC_P4_MASK = 32'hF000_0000;

endpackage

// File: rtl/fabric2_addr_dec.sv
// Combinational window match with fixed priority 1 > 2 > 3 > 4; no match selects the default slave (0).
module fabric2_addr_dec
  import fabric2_mdecoder_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] P1_BASE = FABRIC_P1_BASE,
  parameter logic [ADDR_WIDTH-1:0] P1_MASK = FABRIC_P1_MASK,
  parameter logic [ADDR_WIDTH-1:0] P2_BASE = FABRIC_P2_BASE,
  parameter logic [ADDR_WIDTH-1:0] P2_MASK = FABRIC_P2_MASK,
  parameter logic [ADDR_WIDTH-1:0] P3_BASE = FABRIC_P3_BASE,
  parameter logic [ADDR_WIDTH-1:0] P3_MASK = FABRIC_P3_MASK,
  parameter logic [ADDR_WIDTH-1:0] P4_BASE = FABRIC_P4_BASE,
  parameter logic [ADDR_WIDTH-1:0] P4_MASK = FABRIC_P4_MASK
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [PORT_IDX_W-1:0] port_o
);

  // Lowest priority first so a later, higher-priority match overrides it.
  always_comb begin
    port_o = '0;
    if ((addr_i & P4_MASK) == P4_BASE) port_o = 3'd4;
    if ((addr_i & P3_MASK) == P3_BASE) port_o = 3'd3;
    if ((addr_i & P2_MASK) == P2_BASE) port_o = 3'd2;
    if ((addr_i & P1_MASK) == P1_BASE) port_o = 3'd1;
  end

endmodule

// File: rtl/fabric2_mdecoder.sv
// Master address decoder and transaction tracker: drives the switch port select, holds it
// from command issue to response, and recovers via a watchdog when a slave never answers.
module fabric2_mdecoder
  import fabric2_mdecoder_pkg::*;
#(
  parameter int                    PORTNO_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] P1_BASE      = FABRIC_P1_BASE,
  parameter logic [ADDR_WIDTH-1:0] P1_MASK      = FABRIC_P1_MASK,
  parameter logic [ADDR_WIDTH-1:0] P2_BASE      = FABRIC_P2_BASE,
  parameter logic [ADDR_WIDTH-1:0] P2_MASK      = FABRIC_P2_MASK,
  parameter logic [ADDR_WIDTH-1:0] P3_BASE      = FABRIC_P3_BASE,
  parameter logic [ADDR_WIDTH-1:0] P3_MASK      = FABRIC_P3_MASK,
  parameter logic [ADDR_WIDTH-1:0] P4_BASE      = FABRIC_P4_BASE,
  parameter logic [ADDR_WIDTH-1:0] P4_MASK      = FABRIC_P4_MASK,
  parameter int                    TMO_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   i_ID_MAddr,
  input  logic [2:0]              i_ID_MCmd,
  input  logic                    i_ID_SCmdAccept,
  input  logic [1:0]              i_ID_SResp,
  output logic [PORTNO_WIDTH-1:0] o_portno,
  output logic                    o_busy,
  output logic                    o_tmo
);

  logic [PORT_IDX_W-1:0] dec_port;
  logic [PORT_IDX_W-1:0] sel_q;
  state_e                state_q;
  logic [TMO_WIDTH-1:0]  wdog_q;
  logic [TMO_WIDTH-1:0]  wdog_d;
  logic                  busy_q, tmo_q, hold_q;
  logic                  new_cmd, resp_done, expire;

  fabric2_addr_dec #(
    .P1_BASE(P1_BASE), .P1_MASK(P1_MASK),
    .P2_BASE(P2_BASE), .P2_MASK(P2_MASK),
    .P3_BASE(P3_BASE), .P3_MASK(P3_MASK),
    .P4_BASE(P4_BASE), .P4_MASK(P4_MASK)
  ) u_dec (
    .addr_i (i_ID_MAddr),
    .port_o (dec_port)
  );

  // hold_q blocks sampling in the first IDLE cycle after any completion or timeout.
  assign new_cmd   = (i_ID_MCmd != CMD_IDLE) && !hold_q;
  assign resp_done = (i_ID_SResp != RESP_NULL);
  assign wdog_d    = wdog_q + 1'b1;
  assign expire    = &wdog_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      wdog_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      tmo_q  <= 1'b0;
      hold_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (new_cmd) begin
            sel_q  <= dec_port;
            wdog_q <= '0;
            if (!i_ID_SCmdAccept) begin
              state_q <= ST_CMD;
              busy_q  <= 1'b1;
            end else if (!resp_done) begin
              state_q <= ST_RESP;
              busy_q  <= 1'b1;
            end else begin
              hold_q <= 1'b1;
            end
          end
        end
        ST_CMD, ST_RESP: begin
          // Completion is checked before expiry so a same-cycle response wins.
          if ((state_q == ST_RESP || i_ID_SCmdAccept) && resp_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            wdog_q  <= '0;
            hold_q  <= 1'b1;
          end else if (expire) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            wdog_q  <= '0;
            tmo_q   <= 1'b1;
            hold_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_d;
            if (state_q == ST_CMD && i_ID_SCmdAccept) state_q <= ST_RESP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_portno = (state_q == ST_IDLE) ? PORTNO_WIDTH'(dec_port) : PORTNO_WIDTH'(sel_q);
  assign o_busy   = busy_q;
  assign o_tmo    = tmo_q;

endmodule

// File: tb/tb_fabric2_mdecoder.sv
// Bench for fabric2_mdecoder: decode table, scoreboarded transactions, watchdog and reset corners.
module tb_fabric2_mdecoder;
  import fabric2_mdecoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] maddr;
  logic [2:0]  mcmd;
  logic        acc;
  logic [1:0]  sresp;
  logic [10:0] portno, ovl_portno;
  logic        busy, tmo, ovl_busy, ovl_tmo;

  int npass = 0;
  int ntotal = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  fabric2_mdecoder #(.PORTNO_WIDTH(11), .TMO_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_ID_MAddr(maddr), .i_ID_MCmd(mcmd),
    .i_ID_SCmdAccept(acc), .i_ID_SResp(sresp),
    .o_portno(portno), .o_busy(busy), .o_tmo(tmo)
  );

  // Overlapping windows: port 2 aliases port 1, so port 1 must win.
  fabric2_mdecoder #(.PORTNO_WIDTH(11), .TMO_WIDTH(4),
                     .P2_BASE(32'h1000_0000), .P2_MASK(32'hF000_0000)) u_ovl (
    .clk(clk), .rst(rst), .i_ID_MAddr(maddr), .i_ID_MCmd(mcmd),
    .i_ID_SCmdAccept(acc), .i_ID_SResp(sresp),
    .o_portno(ovl_portno), .o_busy(ovl_busy), .o_tmo(ovl_tmo)
  );

  typedef struct {
    logic [31:0] addr;
    logic [10:0] port;
    logic [10:0] ovl;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] c, input logic ac, input logic [1:0] r);
    maddr = a; mcmd = c; acc = ac; sresp = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string nm);
    logic [10:0] e;
    if (sb_q.size() == 0) begin
      ntotal++;
      $display("FAIL %s: scoreboard empty, got port %0h", nm, portno);
    end else begin
      e = sb_q.pop_front();
      chk(nm, 32'(portno), 32'(e));
    end
  endtask

  initial begin
    int nbusy;
    tbl[0] = '{32'h0000_0000, 11'd0, 11'd0};
    tbl[1] = '{32'h1000_0004, 11'd1, 11'd1};
    tbl[2] = '{32'h2000_0010, 11'd2, 11'd0};
    tbl[3] = '{32'h3FFF_FFFF, 11'd3, 11'd3};
    tbl[4] = '{32'h4ABC_0000, 11'd4, 11'd4};
    tbl[5] = '{32'h5000_0000, 11'd0, 11'd0};
    tbl[6] = '{32'hF000_0000, 11'd0, 11'd0};
    tbl[7] = '{32'h1FFF_FFFF, 11'd1, 11'd1};
    tbl[8] = '{32'h0FFF_FFFF, 11'd0, 11'd0};

    rst = 1'b1;
    drive(32'h0, CMD_IDLE, 1'b0, RESP_NULL);
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_portno", 32'(portno), 32'd0);
    rst = 1'b0;
    tick();

    // Live decode in IDLE, both address maps.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].addr, CMD_IDLE, 1'b0, RESP_NULL);
      chk($sformatf("dec[%0d]", i), 32'(portno), 32'(tbl[i].port));
      chk($sformatf("ovl[%0d]", i), 32'(ovl_portno), 32'(tbl[i].ovl));
      chk($sformatf("ovl_busy[%0d]", i), 32'(ovl_busy), 32'd0);
      tick();
    end

    // Read to port 2: accept in cycle 2, DVA in cycle 5, address moves to port 4 during RESP.
    nbusy = 0;
    drive(32'h2000_0010, CMD_RD, 1'b0, RESP_NULL);
    chk("rd_c0_port", 32'(portno), 32'd2);
    chk("rd_c0_busy", 32'(busy), 32'd0);
    sb_q.push_back(11'd2);
    tick();
    drive(32'h2000_0010, CMD_RD, 1'b0, RESP_NULL);
    nbusy += int'(busy);
    chk("rd_c1_port", 32'(portno), 32'd2);
    tick();
    drive(32'h2000_0010, CMD_RD, 1'b1, RESP_NULL);
    nbusy += int'(busy);
    chk("rd_c2_port", 32'(portno), 32'd2);
    tick();
    drive(32'h2000_0010, CMD_IDLE, 1'b0, RESP_NULL);
    nbusy += int'(busy);
    chk("rd_c3_port", 32'(portno), 32'd2);
    tick();
    drive(32'h4000_0000, CMD_IDLE, 1'b0, RESP_NULL);
    nbusy += int'(busy);
    chk("rd_c4_hold", 32'(portno), 32'd2);
    tick();
    drive(32'h4000_0000, CMD_IDLE, 1'b0, RESP_DVA);
    nbusy += int'(busy);
    sb_pop("rd_done_port");
    tick();
    drive(32'h4000_0000, CMD_IDLE, 1'b0, RESP_NULL);
    nbusy += int'(busy);
    chk("rd_idle_port", 32'(portno), 32'd4);
    chk("rd_busy_cycles", 32'(nbusy), 32'd5);
    tick();

    // Unmapped write, accept and DVA in the same cycle: never busy.
    drive(32'hF000_0000, CMD_WR, 1'b1, RESP_DVA);
    sb_q.push_back(11'd0);
    sb_pop("wr1_port");
    tick();
    drive(32'hF000_0000, CMD_IDLE, 1'b0, RESP_NULL);
    chk("wr1_busy_a", 32'(busy), 32'd0);
    tick();
    chk("wr1_busy_b", 32'(busy), 32'd0);
    tick();

    // Slave never answers: counter clears at sampling (end of cycle 0), expires 15 clocks later.
    drive(32'h3000_0000, CMD_RD, 1'b0, RESP_NULL);
    sb_q.push_back(11'd3);
    tick();
    for (int k = 1; k <= 15; k++) begin
      drive(32'h3000_0000, CMD_IDLE, 1'b0, RESP_NULL);
      chk($sformatf("tmo_wait_tmo[%0d]", k), 32'(tmo), 32'd0);
      chk($sformatf("tmo_wait_busy[%0d]", k), 32'(busy), 32'd1);
      if (k == 15) sb_pop("tmo_port");
      tick();
    end
    chk("tmo_pulse", 32'(tmo), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    tick();
    chk("tmo_one_cycle", 32'(tmo), 32'd0);
    tick();

    // Response lands in the same cycle the watchdog would expire: completion wins.
    drive(32'h1000_0000, CMD_WR, 1'b0, RESP_NULL);
    sb_q.push_back(11'd1);
    tick();
    drive(32'h1000_0000, CMD_WR, 1'b1, RESP_NULL);
    tick();
    for (int k = 2; k <= 14; k++) begin
      drive(32'h0, CMD_IDLE, 1'b0, RESP_NULL);
      tick();
    end
    drive(32'h0, CMD_IDLE, 1'b0, RESP_ERR);
    chk("race_busy", 32'(busy), 32'd1);
    sb_pop("race_port");
    tick();
    drive(32'h0, CMD_IDLE, 1'b0, RESP_NULL);
    chk("race_tmo", 32'(tmo), 32'd0);
    chk("race_idle", 32'(busy), 32'd0);
    tick();

    // Reset during CMD, then a fresh command decodes normally.
    drive(32'h2000_0000, CMD_RD, 1'b0, RESP_NULL);
    tick();
    chk("rstmid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    drive(32'h2000_0000, CMD_IDLE, 1'b0, RESP_NULL);
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_tmo", 32'(tmo), 32'd0);
    drive(32'h4000_0100, CMD_WR, 1'b1, RESP_NULL);
    chk("fresh_port", 32'(portno), 32'd4);
    sb_q.push_back(11'd4);
    tick();
    drive(32'h1000_0000, CMD_IDLE, 1'b0, RESP_NULL);
    chk("fresh_busy", 32'(busy), 32'd1);
    chk("fresh_hold", 32'(portno), 32'd4);
    tick();
    drive(32'h1000_0000, CMD_IDLE, 1'b0, RESP_DVA);
    sb_pop("fresh_done_port");
    tick();
    drive(32'h1000_0000, CMD_IDLE, 1'b0, RESP_NULL);
    chk("fresh_end_busy", 32'(busy), 32'd0);
    chk("fresh_end_port", 32'(portno), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
